seq_gen: RTL and testbench



---
 rtl/seq_pkg.sv | 26 ++
 rtl/shreg_piso.sv | 52 +++++
 rtl/seq_gen.sv | 156 +++++++++++++++
 tb/tb_seq_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern transmitter (seq_gen) and the
// Moore sequence detectors it drives. The detector benches import the state
// encoding from here, so the numeric values below must stay stable.
//
// Contents:
//   SEQ_IDLE / SEQ_SHIFT / SEQ_DONE : 2-bit state encoding
//   SEQ_MAX_WIDTH                   : largest supported pattern length
//   seq_state_e                     : enum built on the encoding above
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam logic [1:0] SEQ_IDLE  = 2'b00;
  localparam logic [1:0] SEQ_SHIFT = 2'b01;
  localparam logic [1:0] SEQ_DONE  = 2'b10;

  localparam int unsigned SEQ_MAX_WIDTH = 32'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = SEQ_IDLE,
    ST_SHIFT = SEQ_SHIFT,
    ST_DONE  = SEQ_DONE
  } seq_state_e;

endpackage : seq_pkg

// File: rtl/shreg_piso.sv
// -----------------------------------------------------------------------------
// shreg_piso
// Parallel-in / serial-out shift register, MSB first. A load has priority
// over a shift. Zeros are shifted in at the LSB, so after a full pass the
// register is empty.
//
// Ports:
//   clk_i    in   1      rising-edge clock
//   rst_ni   in   1      synchronous active-low reset (clears the register)
//   load_i   in   1      capture data_i on this edge
//   shift_i  in   1      shift left by one on this edge
//   data_i   in   WIDTH  parallel load value
//   msb_o    out  1      current MSB (registered)
// -----------------------------------------------------------------------------
module shreg_piso #(
  parameter int unsigned WIDTH = 32'd8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Next-state selection: load wins over shift, otherwise hold.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Shift register storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule : shreg_piso

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen
// Serial pattern transmitter feeding the single-bit w line of the Moore
// sequence detectors. A start request in IDLE captures a WIDTH-bit pattern,
// which is then sent MSB first, one bit per clock, followed by a one-cycle
// done pulse and a return to IDLE.
//
// Optional feature, macro SEQ_GEN_REPEAT_EN:
//   defined   - with repeat_i high when the last bit is sent, the pattern is
//               reloaded from an internal copy and streaming continues with
//               no gap and no done pulse.
//   undefined - repeat_i is ignored and the internal copy does not exist.
//
// Ports:
//   clock      in   1      rising-edge system clock
//   reset_n    in   1      synchronous active-low reset
//   start_i    in   1      load request, honoured only in IDLE
//   pattern_i  in   WIDTH  bits to transmit, captured on the accepting edge
//   repeat_i   in   1      continuous-mode request
//   w_o        out  1      serial data, MSB first, 0 whenever valid_o is 0
//   valid_o    out  1      w_o carries a pattern bit
//   busy_o     out  1      high in SHIFT and DONE
//   done_o     out  1      one-cycle pulse after the last bit
//
// All outputs decode registered state only; no input reaches an output
// combinationally. WIDTH legal range is 2..SEQ_MAX_WIDTH.
// -----------------------------------------------------------------------------
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             repeat_i,
  output logic             w_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_s;
  logic             shift_s;
  logic [WIDTH-1:0] load_data_s;
  logic             msb_s;

`ifdef SEQ_GEN_REPEAT_EN
  logic [WIDTH-1:0] pat_q;

  // Keep a copy of the accepted pattern so later passes can reload it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pat_q <= '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      pat_q <= pattern_i;
    end else begin
      pat_q <= pat_q;
    end
  end
`else
  // repeat_i is kept on the port for a uniform interface but has no effect.
  logic repeat_unused_s;
  assign repeat_unused_s = repeat_i;
`endif

  // Next-state, counter and shift-register control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    load_data_s = pattern_i;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_s  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
`ifdef SEQ_GEN_REPEAT_EN
          if (repeat_i) begin
            // Reload on the same edge the last bit leaves, so the stream
            // continues without a gap.
            load_s      = 1'b1;
            load_data_s = pat_q;
            cnt_d       = CNT_LOAD;
            state_d     = ST_SHIFT;
          end else begin
            shift_s = 1'b1;
            state_d = ST_DONE;
          end
`else
          shift_s = 1'b1;
          state_d = ST_DONE;
`endif
        end else begin
          // Counter is non-zero here, so the decrement never wraps.
          shift_s = 1'b1;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and bit-counter registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shreg_piso #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .load_i  (load_s),
    .shift_i (shift_s),
    .data_i  (load_data_s),
    .msb_o   (msb_s)
  );

  // Status decode from registered state; w is gated so it is 0 outside SHIFT.
  assign valid_o = (state_q == ST_SHIFT);
  assign w_o     = (state_q == ST_SHIFT) & msb_s;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);

endmodule : seq_gen

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen
// Directed, table-driven bench for seq_gen. Each record gives the inputs held
// across one rising edge and the {w, valid, busy, done} expected just after
// that edge. A second instance with WIDTH=4 covers continuous mode.
// -----------------------------------------------------------------------------
module tb_seq_gen;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic [7:0] pat;
    logic       rpt;
    logic [3:0] exp;
  } vec_t;

  localparam logic [3:0] O_IDLE = 4'b0000;
  localparam logic [3:0] O_DONE = 4'b0011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start;
  logic [7:0] pat;
  logic       rpt;
  logic       w, valid, busy, done;

  logic       start4;
  logic [3:0] pat4;
  logic       rpt4;
  logic       w4, valid4, busy4, done4;

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs[$];

  seq_gen #(.WIDTH(8)) u_dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .start_i   (start),
    .pattern_i (pat),
    .repeat_i  (rpt),
    .w_o       (w),
    .valid_o   (valid),
    .busy_o    (busy),
    .done_o    (done)
  );

  seq_gen #(.WIDTH(4)) u_dut4 (
    .clock     (clk),
    .reset_n   (reset_n),
    .start_i   (start4),
    .pattern_i (pat4),
    .repeat_i  (rpt4),
    .w_o       (w4),
    .valid_o   (valid4),
    .busy_o    (busy4),
    .done_o    (done4)
  );

  function automatic logic [3:0] sh(input logic b);
    return {b, 3'b110};
  endfunction

  task automatic add(input string nm, input logic r, input logic s,
                     input logic [7:0] p, input logic rp, input logic [3:0] e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.start = s; v.pat = p; v.rpt = rp; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: {w,valid,busy,done} got %b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    logic [7:0] pa, pb, pc, pd;
    logic [3:0] p4, e4;
    pa = 8'b1011_0010;
    pb = 8'b0100_1101;
    pc = 8'b1000_0001;
    pd = 8'b0111_1110;
    p4 = 4'b1100;

    reset_n = 1'b0; start = 1'b0; pat = 8'h00; rpt = 1'b0;
    start4 = 1'b0; pat4 = 4'h0; rpt4 = 1'b0;

    // Reset (start during reset must be ignored), then idle.
    add("rst0", 1'b0, 1'b0, 8'h00, 1'b0, O_IDLE);
    add("rst_vs_start", 1'b0, 1'b1, 8'hFF, 1'b1, O_IDLE);
    for (int i = 0; i < 10; i++) add("idle", 1'b1, 1'b0, 8'hA5, 1'b0, O_IDLE);

    // Single transfer.
    add("A_acc", 1'b1, 1'b1, pa, 1'b0, sh(pa[7]));
    for (int i = 6; i >= 0; i--) add("A_bit", 1'b1, 1'b0, 8'h00, 1'b0, sh(pa[i]));
    add("A_done", 1'b1, 1'b0, 8'h00, 1'b0, O_DONE);
    add("A_idle", 1'b1, 1'b0, 8'h00, 1'b0, O_IDLE);

    // Start while busy at N+4 must be ignored and not queued.
    add("B_acc", 1'b1, 1'b1, pb, 1'b0, sh(pb[7]));
    for (int i = 6; i >= 0; i--)
      add("B_bit", 1'b1, (i == 3) ? 1'b1 : 1'b0, (i == 3) ? 8'hFF : 8'h00, 1'b0, sh(pb[i]));
    add("B_done", 1'b1, 1'b0, 8'h00, 1'b0, O_DONE);
    add("B_idle", 1'b1, 1'b0, 8'h00, 1'b0, O_IDLE);
    add("B_noqueue", 1'b1, 1'b0, 8'h00, 1'b0, O_IDLE);

    // Start held high: next acceptance exactly WIDTH+2 cycles later.
    add("C_acc", 1'b1, 1'b1, pc, 1'b0, sh(pc[7]));
    for (int i = 6; i >= 0; i--) add("C_bit", 1'b1, 1'b1, pd, 1'b0, sh(pc[i]));
    add("C_done", 1'b1, 1'b1, pd, 1'b0, O_DONE);
    add("C_gap", 1'b1, 1'b1, pd, 1'b0, O_IDLE);
    add("C_reacc", 1'b1, 1'b1, pd, 1'b0, sh(pd[7]));
    for (int i = 6; i >= 0; i--) add("C2_bit", 1'b1, 1'b0, 8'h00, 1'b0, sh(pd[i]));
    add("C2_done", 1'b1, 1'b0, 8'h00, 1'b0, O_DONE);
    add("C2_idle", 1'b1, 1'b0, 8'h00, 1'b0, O_IDLE);

    // Reset at N+5 aborts without a done pulse.
    add("D_acc", 1'b1, 1'b1, 8'hFF, 1'b0, sh(1'b1));
    for (int i = 0; i < 4; i++) add("D_bit", 1'b1, 1'b0, 8'h00, 1'b0, sh(1'b1));
    add("D_rst", 1'b0, 1'b0, 8'h00, 1'b0, O_IDLE);
    for (int i = 0; i < 3; i++) add("D_after", 1'b1, 1'b0, 8'h00, 1'b0, O_IDLE);

    foreach (vecs[k]) begin
      reset_n = vecs[k].rst_n;
      start   = vecs[k].start;
      pat     = vecs[k].pat;
      rpt     = vecs[k].rpt;
      @(posedge clk);
      #1;
      check(vecs[k].name, {w, valid, busy, done}, vecs[k].exp);
    end
    start = 1'b0;

    // WIDTH=4 instance idle after the whole table.
    check("W4_idle", {w4, valid4, busy4, done4}, O_IDLE);

    // Continuous mode: repeat high for the accept edge and 10 cycles after.
    for (int k = 0; k < 16; k++) begin
      start4 = (k == 0) ? 1'b1 : 1'b0;
      pat4   = (k == 0) ? p4 : 4'b0011;
      rpt4   = (k <= 10) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
`ifdef SEQ_GEN_REPEAT_EN
      if (k < 12)       e4 = sh(p4[3 - (k % 4)]);
      else if (k == 12) e4 = O_DONE;
      else              e4 = O_IDLE;
`else
      if (k < 4)        e4 = sh(p4[3 - k]);
      else if (k == 4)  e4 = O_DONE;
      else              e4 = O_IDLE;
`endif
      check("W4_repeat", {w4, valid4, busy4, done4}, e4);
    end
    start4 = 1'b0;
    rpt4   = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_gen
